// File: rtl/trace_line_sched.sv
// Round-robin scheduler packing requester text segments into one line buffer.
// A closed line drains as a byte stream terminated by a newline.
module trace_line_sched #(
    parameter int         NREQ   = 4,
    parameter int         NCHARS = 64,
    parameter logic [7:0] SEP    = 8'h7C
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_val,
    input  logic [8*NREQ-1:0] req_char,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_rdy,
    input  logic              line_end,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [7:0]        out_char,
    output logic              out_last,
    output logic              busy,
    output logic              overflow,
    output logic [31:0]       line_count
);

    localparam int IW  = $clog2(NREQ);
    localparam int AW  = $clog2(NCHARS);
    localparam int WPW = AW + 1;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_SEP,
        ST_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [WPW-1:0]  wp_q, wp_d;
    logic [WPW-1:0]  rp_q, rp_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic            end_pend_q, end_pend_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     line_count_q, line_count_d;
    logic [7:0]      mem_q [NCHARS];

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    int              scan;
    logic            push_en;
    logic [7:0]      push_char;
    logic            wr_en;
    logic [NREQ-1:0] rdy_c;
    logic            end_req;
    logic            line_full;
    logic            have_char;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == IW'(NREQ - 1)) begin
            return '0;
        end
        return i + IW'(1);
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan = int'(rr_ptr_q) + k;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            if (!pick_found && req_val[scan]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(scan);
            end
        end
    end

    assign end_req   = end_pend_q | line_end;
    assign line_full = (wp_q == WPW'(NCHARS));
    assign have_char = (rp_q < wp_q);

    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        rp_d         = rp_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        end_pend_d   = end_pend_q;
        overflow_d   = overflow_q;
        line_count_d = line_count_q;
        rdy_c        = '0;
        push_en      = 1'b0;
        push_char    = req_char[8*int'(grant_q) +: 8];
        out_val      = 1'b0;
        out_char     = 8'h0A;
        out_last     = 1'b0;

        unique case (state_q)
            ST_COLLECT: begin
                if (line_end) begin
                    end_pend_d = 1'b1;
                end
                if (lock_q) begin
                    rdy_c[grant_q] = 1'b1;
                    if (req_val[grant_q]) begin
                        push_en = 1'b1;
                        if (req_last[grant_q]) begin
                            lock_d   = 1'b0;
                            rr_ptr_d = next_idx(grant_q);
                            if (end_req) begin
                                state_d    = ST_DRAIN;
                                end_pend_d = 1'b0;
                                rp_d       = '0;
                            end
                        end
                    end
                end else if (end_req) begin
                    state_d    = ST_DRAIN;
                    end_pend_d = 1'b0;
                    rp_d       = '0;
                end else if (pick_found) begin
                    grant_d = pick_idx;
                    if (wp_q == '0) begin
                        rdy_c[pick_idx] = 1'b1;
                        push_en         = 1'b1;
                        push_char       = req_char[8*int'(pick_idx) +: 8];
                        if (req_last[pick_idx]) begin
                            rr_ptr_d = next_idx(pick_idx);
                        end else begin
                            lock_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_SEP;
                    end
                end
            end
            ST_SEP: begin
                if (line_end) begin
                    end_pend_d = 1'b1;
                end
                push_en   = 1'b1;
                push_char = SEP;
                state_d   = ST_COLLECT;
                lock_d    = 1'b1;
            end
            ST_DRAIN: begin
                out_val = 1'b1;
                if (have_char) begin
                    out_char = mem_q[rp_q[AW-1:0]];
                end else begin
                    out_last = 1'b1;
                end
                if (out_rdy) begin
                    if (have_char) begin
                        rp_d = rp_q + WPW'(1);
                    end else begin
                        wp_d         = '0;
                        rp_d         = '0;
                        overflow_d   = 1'b0;
                        line_count_d = line_count_q + 32'd1;
                        state_d      = ST_COLLECT;
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        // A full buffer drops the write but the requester still sees a handshake.
        if (push_en) begin
            if (line_full) begin
                overflow_d = 1'b1;
            end else begin
                wp_d = wp_q + WPW'(1);
            end
        end
    end

    assign wr_en = push_en && !line_full;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_COLLECT;
            wp_q         <= '0;
            rp_q         <= '0;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            end_pend_q   <= 1'b0;
            overflow_q   <= 1'b0;
            line_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            end_pend_q   <= end_pend_d;
            overflow_q   <= overflow_d;
            line_count_q <= line_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wp_q[AW-1:0]] <= push_char;
        end
    end

    assign req_rdy    = reset ? rdy_c : '0;
    assign busy       = (state_q == ST_DRAIN);
    assign overflow   = overflow_q;
    assign line_count = line_count_q;

endmodule

// File: tb/tb_trace_line_sched.sv
// Bench for trace_line_sched: directed timing steps plus random segment
// traffic checked against a line-level round-robin packing model.
module tb_trace_line_sched;

    localparam int NREQ   = 4;
    localparam int NCHARS = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_val;
    logic [8*NREQ-1:0] req_char;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_rdy;
    logic              line_end;
    logic              out_val;
    logic              out_rdy;
    logic [7:0]        out_char;
    logic              out_last;
    logic              busy;
    logic              overflow;
    logic [31:0]       line_count;

    trace_line_sched #(
        .NREQ(NREQ),
        .NCHARS(NCHARS),
        .SEP(8'h7C)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_val(req_val),
        .req_char(req_char),
        .req_last(req_last),
        .req_rdy(req_rdy),
        .line_end(line_end),
        .out_val(out_val),
        .out_rdy(out_rdy),
        .out_char(out_char),
        .out_last(out_last),
        .busy(busy),
        .overflow(overflow),
        .line_count(line_count)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nbad = 0;
    int cyc = 0;
    int m_rr = 0;
    int m_lines = 0;

    byte unsigned qc [NREQ][$];
    bit           ql [NREQ][$];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_s(input string tag, input string obs,
                           input string exp);
        ncmp++;
        assert (obs == exp) else begin
            nbad++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_idle();
        req_val  = '0;
        req_last = '0;
        req_char = '0;
        line_end = 1'b0;
    endtask

    task automatic drive1(input int i, input logic [7:0] c, input bit last);
        drive_idle();
        req_val[i]          = 1'b1;
        req_char[8*i +: 8]  = c;
        req_last[i]         = last;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREQ; i++) begin
            qc[i].delete();
            ql[i].delete();
        end
        m_rr    = 0;
        m_lines = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        to_neg();
        to_next();
        reset = 1'b1;
        clear_model();
    endtask

    task automatic add_seg(input int i, input string s);
        for (int k = 0; k < s.len(); k++) begin
            qc[i].push_back(s[k]);
            ql[i].push_back(k == s.len() - 1);
        end
    endtask

    // Line as the spec's rules build it: round-robin segment order from
    // m_rr, separators between segments, truncated to NCHARS.
    task automatic build_exp(output string exp, output bit ovf);
        int    pos [NREQ];
        string full;
        bit    found;
        int    pick;
        full = "";
        for (int i = 0; i < NREQ; i++) pos[i] = 0;
        forever begin
            found = 0;
            pick  = 0;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_rr + k) % NREQ;
                if (!found && pos[j] < qc[j].size()) begin
                    found = 1;
                    pick  = j;
                end
            end
            if (!found) break;
            if (full.len() > 0) full = {full, "|"};
            forever begin
                full = $sformatf("%s%c", full, qc[pick][pos[pick]]);
                pos[pick]++;
                if (ql[pick][pos[pick]-1]) break;
            end
            m_rr = (pick + 1) % NREQ;
        end
        ovf = (full.len() > NCHARS);
        exp = ovf ? full.substr(0, NCHARS - 1) : full;
    endtask

    task automatic run_line(input bit bubbles, input bit le_early,
                            input int le_gap, input int rdy_pct);
        string           exp, got;
        bit              ovf, done, le_done, any_hs, all_empty;
        bit              midseg [NREQ];
        logic [NREQ-1:0] hs;
        int              gap, t0, last_hs, le_cyc, first_out, want;
        build_exp(exp, ovf);
        got = "";
        done = 0; le_done = 0; any_hs = 0;
        gap = le_gap; t0 = cyc;
        last_hs = -1; le_cyc = -1; first_out = -1;
        for (int i = 0; i < NREQ; i++) midseg[i] = 0;
        while (!done && (cyc - t0) < 3000) begin
            all_empty = 1;
            for (int i = 0; i < NREQ; i++) begin
                if (qc[i].size() > 0) all_empty = 0;
                if (qc[i].size() > 0 &&
                    !(bubbles && midseg[i] && $urandom_range(3, 0) == 0)) begin
                    req_val[i]         = 1'b1;
                    req_char[8*i +: 8] = qc[i][0];
                    req_last[i]        = ql[i][0];
                end else begin
                    req_val[i]         = 1'b0;
                    req_char[8*i +: 8] = 8'($urandom);
                    req_last[i]        = 1'($urandom);
                end
            end
            line_end = 1'b0;
            if (!le_done && (le_early ? any_hs : all_empty)) begin
                if (gap == 0) begin
                    line_end = 1'b1;
                    le_done  = 1;
                    le_cyc   = cyc;
                end else begin
                    gap--;
                end
            end
            out_rdy = ($urandom_range(99, 0) < rdy_pct);
            to_neg();
            if (!$onehot0(req_rdy)) check("rdy_onehot", req_rdy, 0);
            hs = req_val & req_rdy;
            if (out_val) begin
                if (first_out < 0) first_out = cyc;
                check("ovf_drain", overflow, ovf);
                if (out_rdy) begin
                    if (out_last) begin
                        check_s("line", got, exp);
                        check("nl_char", out_char, 8'h0A);
                        done = 1;
                    end else begin
                        got = $sformatf("%s%c", got, out_char);
                    end
                end
            end
            if (hs != '0) begin
                any_hs  = 1;
                last_hs = cyc;
            end
            to_next();
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] && qc[i].size() > 0) begin
                    midseg[i] = !ql[i][0];
                    void'(qc[i].pop_front());
                    void'(ql[i].pop_front());
                end
            end
        end
        drive_idle();
        if (!done) begin
            check("line_timeout", 0, 1);
        end else begin
            m_lines++;
            want = ((le_cyc > last_hs) ? le_cyc : last_hs) + 1;
            to_neg();
            check("line_count", line_count, m_lines);
            check("ovf_clear", overflow, 0);
            check("first_out", first_out, want);
            to_next();
        end
    endtask

    task automatic gen_random_line();
        for (int i = 0; i < NREQ; i++) begin
            int ns;
            ns = $urandom_range(2, 0);
            for (int s = 0; s < ns; s++) begin
                int len;
                len = ($urandom_range(7, 0) == 0) ? $urandom_range(30, 10)
                                                  : $urandom_range(6, 1);
                for (int k = 0; k < len; k++) begin
                    qc[i].push_back(8'($urandom_range(8'h7E, 8'h21)));
                    ql[i].push_back(k == len - 1);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        out_rdy = 1'b0;
        drive_idle();
        req_val = '1;
        to_neg();
        check("rst_rdy_held", req_rdy, 0);
        to_next();
        do_reset();

        to_neg();
        check("rst_rdy", req_rdy, 0);
        check("rst_out_val", out_val, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_lines", line_count, 0);
        to_next();

        // "ab" from requester 0
        drive1(0, 8'h61, 1'b0);
        to_neg();
        check("t1_rdy_a", req_rdy, 4'b0001);
        to_next();
        drive1(0, 8'h62, 1'b1);
        to_neg();
        check("t1_rdy_b", req_rdy, 4'b0001);
        to_next();
        drive_idle();
        line_end = 1'b1;
        out_rdy  = 1'b1;
        to_neg();
        check("t1_busy_pre", busy, 0);
        to_next();
        line_end = 1'b0;
        to_neg();
        check("t1_val_a", out_val, 1);
        check("t1_char_a", out_char, 8'h61);
        check("t1_last_a", out_last, 0);
        check("t1_busy", busy, 1);
        to_next();
        to_neg();
        check("t1_char_b", out_char, 8'h62);
        check("t1_last_b", out_last, 0);
        to_next();
        to_neg();
        check("t1_char_nl", out_char, 8'h0A);
        check("t1_last_nl", out_last, 1);
        to_next();
        to_neg();
        check("t1_val_done", out_val, 0);
        check("t1_lines", line_count, 1);
        to_next();

        // two requesters, then rotation continues from requester 2
        do_reset();
        add_seg(0, "x");
        add_seg(1, "y");
        run_line(0, 0, 0, 100);
        for (int i = 0; i < NREQ; i++) add_seg(i, $sformatf("%c", 8'h61 + i));
        run_line(0, 0, 1, 100);

        // empty line drains only the newline
        run_line(0, 0, 0, 100);

        // line_end while requester 1 is mid-segment
        add_seg(1, "pqr");
        run_line(0, 1, 0, 100);

        // overflow: 70 chars into a 64-char buffer
        for (int k = 0; k < 70; k++) begin
            qc[0].push_back(8'h41 + 8'(k % 26));
            ql[0].push_back(k == 69);
        end
        run_line(1, 0, 2, 70);

        // stalled drain, requests and line_end during drain are ignored
        drive1(2, 8'h6D, 1'b0);
        to_neg();
        to_next();
        drive1(2, 8'h6E, 1'b1);
        to_neg();
        to_next();
        m_rr = 3;
        drive_idle();
        line_end = 1'b1;
        out_rdy  = 1'b0;
        to_neg();
        to_next();
        for (int k = 0; k < 5; k++) begin
            req_val  = '1;
            req_last = '1;
            req_char = {NREQ{8'h51}};
            line_end = (k == 2);
            to_neg();
            check("t5_val", out_val, 1);
            check("t5_char", out_char, 8'h6D);
            check("t5_rdy", req_rdy, 0);
            to_next();
        end
        drive_idle();
        out_rdy = 1'b1;
        to_neg();
        check("t5_char_m", out_char, 8'h6D);
        to_next();
        to_neg();
        check("t5_char_n", out_char, 8'h6E);
        to_next();
        to_neg();
        check("t5_last", out_last, 1);
        to_next();
        m_lines++;
        to_neg();
        check("t5_lines", line_count, m_lines);
        to_next();
        to_neg();
        check("t5_no_redrain", out_val, 0);
        to_next();

        for (int n = 0; n < 20; n++) begin
            gen_random_line();
            run_line(1, 0, $urandom_range(3, 0), 60);
        end

        // reset in the middle of draining "abc"
        drive1(0, 8'h61, 1'b0);
        to_neg();
        to_next();
        drive1(0, 8'h62, 1'b0);
        to_neg();
        to_next();
        drive1(0, 8'h63, 1'b1);
        to_neg();
        to_next();
        drive_idle();
        line_end = 1'b1;
        to_neg();
        to_next();
        line_end = 1'b0;
        out_rdy  = 1'b1;
        to_neg();
        check("t6_char_a", out_char, 8'h61);
        to_next();
        reset = 1'b0;
        to_neg();
        to_next();
        reset = 1'b1;
        clear_model();
        to_neg();
        check("t6_val", out_val, 0);
        check("t6_lines", line_count, 0);
        check("t6_busy", busy, 0);
        to_next();
        add_seg(0, "z");
        run_line(0, 0, 0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
